display_uart_tx: RTL and testbench

Serializes the 40-bit, five-character ASCII `display` word produced by the game and stopwatch blocks onto a UART line toward the host pseudo-terminal. It is the transmitting end of the terminal link: the game tops produce `display`, and this block drives it out as 8N1 serial. It sits beside `rxn_game_top` at the board top, fed by `display` and a one-cycle `send` strobe.

---
 rtl/term_pkg.sv | 31 +++
 rtl/uart_tx_byte.sv | 128 ++++++++++++
 rtl/display_uart_tx.sv | 131 +++++++++++++
 tb/tb_display_uart_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// -----------------------------------------------------------------------------
// term_pkg
// Shared definitions for the terminal link: ASCII control constants, the
// per-byte UART transmit state encoding, the display width in characters and
// a NUL-to-space helper used when serialising display characters.
// No ports (package).
// -----------------------------------------------------------------------------
package term_pkg;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_SP      = 8'h20;
    localparam int         DISPLAY_CHARS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // A NUL character would be invisible on the terminal, so it goes out as a space.
    function automatic logic [7:0] nul_to_space(input logic [7:0] c);
        if (c == 8'h00) begin
            return ASCII_SP;
        end else begin
            return c;
        end
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Single-byte 8N1 serialiser: one start bit (low), eight data bits LSB first,
// one stop bit (high), each CLKS_PER_BIT cycles long.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   load data and begin a byte (honoured only while ready)
//   data[7:0]  in   byte to send, captured when start is honoured
//   ready      out  can accept start this cycle (idle, or last stop-bit cycle)
//   byte_done  out  this cycle is the last cycle of the stop bit
//   tx         out  registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_byte
    import term_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       byte_done,
    output logic       tx
);

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q,  baud_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q,    tx_d;

    logic          baud_last_s;
    logic          byte_done_s;
    logic          ready_s;

    assign baud_last_s = (baud_q == BAUD_LAST);
    assign byte_done_s = (state_q == STOP) && baud_last_s;
    // Accepting a new start on the final stop cycle lets bytes chain with no gap.
    assign ready_s     = (state_q == IDLE) || byte_done_s;

    // Next-state, baud, bit counter, shifter and line-level computation.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_last_s ? {BW{1'b0}} : (baud_q + {{(BW-1){1'b0}}, 1'b1});
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (start && ready_s) begin
            state_d = START;
            baud_d  = {BW{1'b0}};
            bit_d   = 3'd0;
            shift_d = data;
            tx_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_d = {BW{1'b0}};
                    tx_d   = 1'b1;
                end
                START: begin
                    if (baud_last_s) begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end else begin
                        tx_d = 1'b0;
                    end
                end
                DATA: begin
                    if (baud_last_s) begin
                        // Bit counter wraps 7 -> 0 as the byte completes.
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            tx_d    = shift_q[0];
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        bit_d = bit_q;
                    end
                end
                STOP: begin
                    tx_d = 1'b1;
                    if (baud_last_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = STOP;
                    end
                end
                default: begin
                    state_d = IDLE;
                    baud_d  = {BW{1'b0}};
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    // State and registered line output, async reset forces the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign ready     = ready_s;
    assign byte_done = byte_done_s;
    assign tx        = tx_q;

endmodule

// File: rtl/display_uart_tx.sv
// -----------------------------------------------------------------------------
// display_uart_tx
// Sends the five-character display word (first character in [39:32]) as 8N1
// serial, optionally followed by CR LF. The word is captured on acceptance so
// later display changes do not disturb the frame in flight.
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   display[39:0] in   five ASCII characters
//   send          in   request strobe, honoured only when not busy
//   busy          out  frame in progress (registered)
//   done          out  one-cycle pulse at the end of the last stop bit (registered)
//   tx            out  serial line, idle high (registered)
// -----------------------------------------------------------------------------
module display_uart_tx
    import term_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter bit APPEND_CRLF  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] display,
    input  logic        send,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    localparam logic [2:0] LAST_IDX = APPEND_CRLF ? 3'(DISPLAY_CHARS + 1)
                                                  : 3'(DISPLAY_CHARS - 1);
    localparam logic [2:0] MAX_IDX  = 3'(DISPLAY_CHARS + 1);

    logic [39:0] shadow_q, shadow_d;
    logic [2:0]  idx_q,    idx_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;

    logic        start_s;
    logic [7:0]  byte_s;
    logic [2:0]  next_idx_s;
    logic        tx_ready_s;
    logic        byte_done_s;
    logic        tx_s;

    // Byte at position idx of the frame: characters first, then CR and LF.
    function automatic logic [7:0] byte_at(input logic [39:0] d, input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = d[39:32];
            3'd1:    c = d[31:24];
            3'd2:    c = d[23:16];
            3'd3:    c = d[15:8];
            3'd4:    c = d[7:0];
            default: c = 8'h00;
        endcase
        if (idx < 3'(DISPLAY_CHARS)) begin
            return nul_to_space(c);
        end else if (idx == 3'(DISPLAY_CHARS)) begin
            return ASCII_CR;
        end else begin
            return ASCII_LF;
        end
    endfunction

    // Byte sequencer: accept a request, then feed bytes as each one finishes.
    always_comb begin
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        start_s    = 1'b0;
        byte_s     = 8'h00;
        next_idx_s = (idx_q == MAX_IDX) ? idx_q : (idx_q + 3'd1);
        if (!busy_q) begin
            if (send && tx_ready_s) begin
                // First byte comes straight from display so the start bit begins next edge.
                shadow_d = display;
                idx_d    = 3'd0;
                busy_d   = 1'b1;
                start_s  = 1'b1;
                byte_s   = byte_at(display, 3'd0);
            end else begin
                busy_d = 1'b0;
            end
        end else if (byte_done_s) begin
            if (idx_q == LAST_IDX) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                idx_d   = next_idx_s;
                start_s = 1'b1;
                byte_s  = byte_at(shadow_q, next_idx_s);
            end
        end else begin
            busy_d = 1'b1;
        end
    end

    // Sequencer registers and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= 40'h0;
            idx_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .rst_n     (reset),
        .start     (start_s),
        .data      (byte_s),
        .ready     (tx_ready_s),
        .byte_done (byte_done_s),
        .tx        (tx_s)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign tx   = tx_s;

endmodule

// File: tb/tb_display_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_display_uart_tx
// Scoreboard bench: expected bytes are queued when a frame is requested and a
// UART decoder on tx pops and compares them as bytes arrive.
// -----------------------------------------------------------------------------
module tb_display_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_LEN = 7 * 10 * CPB;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        send    = 1'b0;
    logic [39:0] display = 40'h0;
    logic        busy;
    logic        done;
    logic        tx;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    display_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .APPEND_CRLF  (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .display (display),
        .send    (send),
        .busy    (busy),
        .done    (done),
        .tx      (tx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_char(input logic [7:0] c);
        return (c == 8'h00) ? 8'h20 : c;
    endfunction

    task automatic push_frame(input logic [39:0] d);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exp_char(d[39 - 8*i -: 8]));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Drive a one-cycle send at a negedge; check start of frame one edge later.
    task automatic send_frame(input logic [39:0] d);
        @(negedge clk);
        display = d;
        send    = 1'b1;
        push_frame(d);
        @(negedge clk);
        send = 1'b0;
        check("busy_rise", {31'd0, busy}, 32'd1);
        check("tx_start",  {31'd0, tx},   32'd0);
    endtask

    // Count busy cycles until it drops (bounded); returns at the negedge where busy is low.
    task automatic wait_frame(output int len);
        int t;
        len = 0;
        t   = 0;
        while (busy === 1'b1 && t < 2000) begin
            len++;
            @(negedge clk);
            t++;
        end
        check("frame_timeout", {31'd0, (t < 2000)}, 32'd1);
    endtask

    // Done pulse counter.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    // UART decoder: samples mid-bit on negedges, compares each byte with the scoreboard.
    initial begin
        logic [7:0] sh;
        int         ph;
        int         k;
        bit         act;
        act = 1'b0;
        ph  = 0;
        k   = 0;
        sh  = 8'h00;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx === 1'b0) begin
                    act = 1'b1;
                    ph  = 0;
                end
            end else begin
                ph++;
                if (ph % CPB == CPB / 2) begin
                    k = ph / CPB;
                    if (k == 0) begin
                        check("start_bit", {31'd0, tx}, 32'd0);
                    end else if (k <= 8) begin
                        sh = {tx, sh[7:1]};
                    end else begin
                        check("stop_bit", {31'd0, tx}, 32'd1);
                        if (exp_q.size() == 0) begin
                            check("rx_unexpected", {24'd0, sh}, 32'h100);
                        end else begin
                            check("rx_byte", {24'd0, sh}, {24'd0, exp_q.pop_front()});
                        end
                        act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int len;
        int bad;
        int d0;

        // Reset state while reset is held.
        repeat (3) @(negedge clk);
        check("rst_tx",   {31'd0, tx},   32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b1;

        // 1: idle for 100 cycles with no request.
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("idle_bad_cycles", bad, 32'd0);

        // 2: HELLO with CR LF, busy length and done pulse.
        d0 = done_cnt;
        send_frame(40'h48_45_4C_4C_4F);
        wait_frame(len);
        check("busy_len_hello", len, FRAME_LEN);
        check("done_at_fall", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("done_count_hello", done_cnt - d0, 32'd1);
        check("sb_drained_hello", exp_q.size(), 32'd0);

        // 3: NUL characters become spaces.
        send_frame(40'h00_31_00_32_00);
        wait_frame(len);
        check("busy_len_nul", len, FRAME_LEN);
        check("sb_drained_nul", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);

        // 4: display change and re-send during a frame are ignored.
        d0 = done_cnt;
        send_frame(40'h41_42_43_44_45);
        repeat (8) @(negedge clk);
        display = 40'h5A_5A_5A_5A_5A;
        repeat (40) @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_frame(len);
        repeat (100) @(negedge clk);
        check("ignored_send_busy", {31'd0, busy}, 32'd0);
        check("ignored_send_done_count", done_cnt - d0, 32'd1);
        check("sb_drained_ignore", exp_q.size(), 32'd0);

        // 5: send in the done cycle starts the next frame on the next edge.
        send_frame(40'h31_32_33_34_35);
        wait_frame(len);
        check("b2b_done_cycle", {31'd0, done}, 32'd1);
        display = 40'h36_37_38_39_30;
        send    = 1'b1;
        push_frame(40'h36_37_38_39_30);
        @(negedge clk);
        send = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_tx",   {31'd0, tx},   32'd0);
        wait_frame(len);
        check("busy_len_b2b", len, FRAME_LEN);
        check("sb_drained_b2b", exp_q.size(), 32'd0);

        // 6: reset mid-DATA of byte 3 takes effect without a clock edge.
        send_frame(40'h48_45_4C_4C_4F);
        repeat (126) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_tx",   {31'd0, tx},   32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(40'h48_45_4C_4C_4F);
        wait_frame(len);
        check("busy_len_after_reset", len, FRAME_LEN);
        check("sb_drained_after_reset", exp_q.size(), 32'd0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
